// File: rtl/sys_defs.sv
// Shared load-path definitions: load buffer packet, load FSM states and
// RV32 load funct3 encodings.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic                   valid;
    logic [XLEN-1:0]        address;
    logic [ROB_TAG_LEN-1:0] rd_tag;
    logic [2:0]             mem_size;
  } LB_PACKET;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } LOAD_STATE;

endpackage

// File: rtl/load_exec_unit_align.sv
// Combinational extraction of a byte/halfword/word from a 64-bit memory
// doubleword, with sign or zero extension chosen by the load funct3.
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [63:0]     data,
  input  logic [2:0]      offset,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] value
);
  import sys_defs::*;

  logic [63:0] shifted_s;

  // Bring the addressed byte down to bit 0, then extend per access size.
  always_comb begin
    shifted_s = data >> {offset, 3'b000};
    value     = '0;
    case (mem_size)
      LB:      value = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      LH:      value = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      LW:      value = shifted_s[XLEN-1:0];
      LBU:     value = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      LHU:     value = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/load_exec_unit.sv
// Single-outstanding load execution stage: request the containing doubleword,
// align/extend the result and hold it for the CDB until granted.
module load_exec_unit #(
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = sys_defs::ROB_TAG_LEN
) (
  input  logic                   clock,
  input  logic                   reset,
  input  sys_defs::LB_PACKET     lb_packet_in,
  output logic                   load_stall,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rsp_valid,
  input  logic [63:0]            mem_rsp_data,
  output logic                   cdb_valid,
  output logic [ROB_TAG_LEN-1:0] cdb_tag,
  output logic [XLEN-1:0]        cdb_value,
  input  logic                   cdb_grant
);
  import sys_defs::*;

  LOAD_STATE              state_r, next_state_s;
  logic [XLEN-1:0]        address_r;
  logic [ROB_TAG_LEN-1:0] rd_tag_r;
  logic [2:0]             mem_size_r;
  logic [XLEN-1:0]        result_r;
  logic [XLEN-1:0]        aligned_s;
  logic                   accept_s;

  load_align #(.XLEN(XLEN)) u_align (
    .data     (mem_rsp_data),
    .offset   (address_r[2:0]),
    .mem_size (mem_size_r),
    .value    (aligned_s)
  );

  // Stall decode; a DONE result being granted frees the unit in the same cycle.
  always_comb begin
    load_stall = 1'b1;
    accept_s   = 1'b0;
    if ((state_r == IDLE) || ((state_r == DONE) && cdb_grant)) begin
      load_stall = 1'b0;
    end else begin
      load_stall = 1'b1;
    end
    accept_s = lb_packet_in.valid && !load_stall;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = REQ;
        else          next_state_s = IDLE;
      end
      REQ: begin
        if (mem_gnt) next_state_s = WAIT;
        else         next_state_s = REQ;
      end
      WAIT: begin
        if (mem_rsp_valid) next_state_s = DONE;
        else               next_state_s = WAIT;
      end
      DONE: begin
        if (cdb_grant && accept_s) next_state_s = REQ;
        else if (cdb_grant)        next_state_s = IDLE;
        else                       next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, latched load request and registered result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      address_r  <= '0;
      rd_tag_r   <= '0;
      mem_size_r <= 3'b000;
      result_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        address_r  <= lb_packet_in.address;
        rd_tag_r   <= lb_packet_in.rd_tag;
        mem_size_r <= lb_packet_in.mem_size;
      end
      if ((state_r == WAIT) && mem_rsp_valid) begin
        result_r <= aligned_s;
      end
    end
  end

  assign mem_req   = (state_r == REQ);
  assign mem_addr  = {address_r[XLEN-1:3], 3'b000};
  assign cdb_valid = (state_r == DONE);
  assign cdb_tag   = rd_tag_r;
  assign cdb_value = result_r;

endmodule

// File: tb/tb_load_exec_unit.sv
// Self-checking bench for load_exec_unit: directed table, randomized loads
// against a byte-level reference model, and multi-cycle corner sequences.
module tb_load_exec_unit;
  import sys_defs::*;

  logic            clock = 1'b0;
  logic            reset;
  LB_PACKET        lb_pkt;
  logic            load_stall;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic            mem_gnt;
  logic            mem_rsp_valid;
  logic [63:0]     mem_rsp_data;
  logic            cdb_valid;
  logic [4:0]      cdb_tag;
  logic [31:0]     cdb_value;
  logic            cdb_grant;

  int tests = 0;
  int fails = 0;

  load_exec_unit dut (
    .clock         (clock),
    .reset         (reset),
    .lb_packet_in  (lb_pkt),
    .load_stall    (load_stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .cdb_grant     (cdb_grant)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [31:0] exp;
    int          g;
    int          r;
    int          k;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: assemble the addressed bytes little-endian, then extend.
  function automatic logic [31:0] ref_load(input logic [63:0] data, input int o, input logic [2:0] size);
    logic [7:0]  b [8];
    logic [63:0] v;
    int          n;
    bit          sgn;
    for (int i = 0; i < 8; i++) b[i] = data[8*i +: 8];
    case (size)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: begin n = 4; sgn = 1'b0; end
      3'd4: begin n = 1; sgn = 1'b0; end
      3'd5: begin n = 2; sgn = 1'b0; end
      default: return 32'd0;
    endcase
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(b[o+i]) << (8*i));
    if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v[31:0];
  endfunction

  // Full load transaction; enters and leaves at a negedge with the unit idle.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data,
                          input logic [31:0] exp, input int g, input int r, input int k);
    logic [4:0] tag;
    int cyc;
    tag = 5'($urandom_range(0, 31));
    lb_pkt.valid = 1'b1; lb_pkt.address = addr; lb_pkt.rd_tag = tag; lb_pkt.mem_size = size;
    #1 check("accept_stall", 64'(load_stall), 64'd0);
    @(posedge clock); @(negedge clock);
    lb_pkt.valid = 1'b0; lb_pkt.address = 32'($urandom);
    cyc = 1;
    check("req_mem_req", 64'(mem_req), 64'd1);
    check("req_mem_addr", 64'(mem_addr), 64'(addr & 32'hFFFF_FFF8));
    for (int i = 0; i < g; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = {$urandom, $urandom};
      @(negedge clock); cyc++;
      check("hold_mem_req", 64'(mem_req), 64'd1);
      check("hold_mem_addr", 64'(mem_addr), 64'(addr & 32'hFFFF_FFF8));
      check("hold_stall", 64'(load_stall), 64'd1);
    end
    mem_rsp_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clock); cyc++;
    mem_gnt = 1'b0;
    check("wait_mem_req", 64'(mem_req), 64'd0);
    for (int i = 0; i < r; i++) begin
      @(negedge clock); cyc++;
      check("wait_cdb_valid", 64'(cdb_valid), 64'd0);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
    @(negedge clock); cyc++;
    mem_rsp_valid = 1'b0; mem_rsp_data = {$urandom, $urandom};
    check("done_cdb_valid", 64'(cdb_valid), 64'd1);
    check("latency", 64'(cyc), 64'(3 + g + r));
    check("cdb_value", 64'(cdb_value), 64'(exp));
    check("cdb_tag", 64'(cdb_tag), 64'(tag));
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      check("held_valid", 64'(cdb_valid), 64'd1);
      check("held_value", 64'(cdb_value), 64'(exp));
      check("held_tag", 64'(cdb_tag), 64'(tag));
      check("held_stall", 64'(load_stall), 64'd1);
    end
    cdb_grant = 1'b1;
    #1 check("grant_stall", 64'(load_stall), 64'd0);
    @(negedge clock);
    cdb_grant = 1'b0;
    check("idle_cdb_valid", 64'(cdb_valid), 64'd0);
    check("idle_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    lb_pkt = '0; mem_gnt = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'd0; cdb_grant = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_stall", 64'(load_stall), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_cdb_value", 64'(cdb_value), 64'd0);

    vecs[0] = '{32'h1003, LBU, 64'h8877665544332211, 32'h00000044, 0, 0, 0};
    vecs[1] = '{32'h1006, LH,  64'h8877665544332211, 32'hFFFF8877, 0, 0, 0};
    vecs[2] = '{32'h1006, LHU, 64'h8877665544332211, 32'h00008877, 0, 1, 0};
    vecs[3] = '{32'h1004, LW,  64'h8877665544332211, 32'h88776655, 3, 0, 0};
    vecs[4] = '{32'h1007, LB,  64'h8877665544332211, 32'hFFFFFF88, 0, 0, 2};
    vecs[5] = '{32'h1000, LB,  64'h8877665544332211, 32'h00000011, 1, 2, 1};
    vecs[6] = '{32'h2000, LW,  64'h00000000DEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    vecs[7] = '{32'h1002, 3'b011, 64'h8877665544332211, 32'h00000000, 0, 0, 0};
    foreach (vecs[i]) run_load(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].exp,
                               vecs[i].g, vecs[i].r, vecs[i].k);

    for (int it = 0; it < 40; it++) begin
      logic [2:0]  sz;
      logic [63:0] d;
      logic [31:0] a;
      int          n;
      sz = 3'($urandom_range(0, 7));
      n  = (sz == LH || sz == LHU) ? 2 : (sz == LW) ? 4 : 1;
      a  = {$urandom} & 32'hFFFF_FFF8;
      a  = a | 32'($urandom_range(0, 8 - n));
      d  = {$urandom, $urandom};
      run_load(a, sz, d, ref_load(d, int'(a[2:0]), sz),
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Back-to-back: packet presented in DONE, accepted only with the grant.
    lb_pkt.valid = 1'b1; lb_pkt.address = 32'h3005; lb_pkt.rd_tag = 5'd7; lb_pkt.mem_size = LBU;
    #1 check("b2b_accept1", 64'(load_stall), 64'd0);
    @(posedge clock); @(negedge clock);
    lb_pkt.valid = 1'b0;
    mem_gnt = 1'b1; @(negedge clock); mem_gnt = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000A50000000000; @(negedge clock); mem_rsp_valid = 1'b0;
    lb_pkt.valid = 1'b1; lb_pkt.address = 32'h4002; lb_pkt.rd_tag = 5'd19; lb_pkt.mem_size = LH;
    for (int i = 0; i < 2; i++) begin
      #1 check("b2b_stall_nogrant", 64'(load_stall), 64'd1);
      check("b2b_held_value", 64'(cdb_value), 64'h000000A5);
      check("b2b_held_tag", 64'(cdb_tag), 64'd7);
      @(negedge clock);
    end
    check("b2b_still_done", 64'(cdb_valid), 64'd1);
    cdb_grant = 1'b1;
    #1 check("b2b_grant_stall", 64'(load_stall), 64'd0);
    @(negedge clock);
    cdb_grant = 1'b0; lb_pkt.valid = 1'b0;
    check("b2b_req", 64'(mem_req), 64'd1);
    check("b2b_addr", 64'(mem_addr), 64'h4000);
    check("b2b_cdb_off", 64'(cdb_valid), 64'd0);
    mem_gnt = 1'b1; @(negedge clock); mem_gnt = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h00000000C3B20000; @(negedge clock); mem_rsp_valid = 1'b0;
    check("b2b_value2", 64'(cdb_value), 64'hFFFFC3B2);
    check("b2b_tag2", 64'(cdb_tag), 64'd19);
    cdb_grant = 1'b1; @(negedge clock); cdb_grant = 1'b0;

    // Reset while in WAIT; a late response must be discarded.
    lb_pkt.valid = 1'b1; lb_pkt.address = 32'h5000; lb_pkt.rd_tag = 5'd3; lb_pkt.mem_size = LW;
    @(posedge clock); @(negedge clock);
    lb_pkt.valid = 1'b0;
    mem_gnt = 1'b1; @(negedge clock); mem_gnt = 1'b0;
    check("rw_in_wait", 64'(load_stall), 64'd1);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234567812345678;
    check("rw_stall", 64'(load_stall), 64'd0);
    check("rw_mem_req", 64'(mem_req), 64'd0);
    @(negedge clock); mem_rsp_valid = 1'b0;
    check("rw_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rw_stall2", 64'(load_stall), 64'd0);
    @(negedge clock);
    check("rw_cdb_valid2", 64'(cdb_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
